imc_cmd_sequencer: RTL and testbench

//  Command sequencer directly upstream of the SRAM row decoder. Accepts READ, WRITE and

---
 rtl/imc_cmd_sequencer.sv | 249 ++++++++++++++++++++++++
 tb/tb_imc_cmd_sequencer.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/imc_cmd_sequencer.sv
// Command sequencer for the IMC SRAM row decoder: READ / WRITE / COMPUTE with precharge,
// evaluate and write-back phasing. Optional row-conflict rejection via IMC_ROW_CONFLICT_EN.
module imc_cmd_sequencer #(
    parameter int ADDR_W   = 7,
    parameter int DATA_W   = 128,
    parameter int PRE_CYC  = 1,
    parameter int EVAL_CYC = 2,
    parameter int WR_CYC   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_src_a,
    input  logic [ADDR_W-1:0] cmd_src_b,
    input  logic [ADDR_W-1:0] cmd_dst,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [DATA_W-1:0] sa_data,
    output logic [ADDR_W-1:0] read_address1,
    output logic [ADDR_W-1:0] read_address2,
    output logic              read_enable1,
    output logic              read_enable2,
    output logic [ADDR_W-1:0] write_address,
    output logic              write_enable,
    output logic [DATA_W-1:0] wr_data,
    output logic              precharge_en,
    output logic              sense_en,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err
);

    localparam int MAX_CYC = (PRE_CYC > EVAL_CYC) ?
                             ((PRE_CYC > WR_CYC) ? PRE_CYC : WR_CYC) :
                             ((EVAL_CYC > WR_CYC) ? EVAL_CYC : WR_CYC);
    localparam int CNT_W = $clog2(MAX_CYC) + 1;

    localparam logic [1:0] OP_READ    = 2'b01;
    localparam logic [1:0] OP_WRITE   = 2'b10;
    localparam logic [1:0] OP_COMPUTE = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_EVAL = 3'd2,
        S_WR   = 3'd3,
        S_RESP = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        op_q, op_d;
    logic [ADDR_W-1:0] src_a_q, src_a_d, src_b_q, src_b_d, dst_q, dst_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, sense_q, sense_d;
`ifdef IMC_ROW_CONFLICT_EN
    logic              err_q, err_d;
`endif

    logic              cmd_ready_d, re1_d, re2_d, we_d, pre_d, sen_d, rsp_valid_d, rsp_err_d;
    logic [ADDR_W-1:0] ra1_d, ra2_d, wa_d;
    logic [DATA_W-1:0] wr_data_d, rsp_data_d;

    // Next-state, phase counter and command/sense latches.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        src_a_d = src_a_q;
        src_b_d = src_b_q;
        dst_d   = dst_q;
        wdata_d = wdata_q;
        sense_d = sense_q;
`ifdef IMC_ROW_CONFLICT_EN
        err_d   = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    src_a_d = cmd_src_a;
                    src_b_d = cmd_src_b;
                    dst_d   = cmd_dst;
                    wdata_d = cmd_wdata;
                    sense_d = {DATA_W{1'b0}};
`ifdef IMC_ROW_CONFLICT_EN
                    err_d   = 1'b0;
`endif
                    case (cmd_op)
                        OP_READ: begin
                            state_d = S_PRE;
                            cnt_d   = CNT_W'(PRE_CYC - 1);
                        end
                        OP_WRITE: begin
                            state_d = S_WR;
                            cnt_d   = CNT_W'(WR_CYC - 1);
                        end
                        OP_COMPUTE: begin
`ifdef IMC_ROW_CONFLICT_EN
                            // Same-row operands or in-place destination: reject without touching the array.
                            if ((cmd_src_a == cmd_src_b) || (cmd_dst == cmd_src_a) ||
                                (cmd_dst == cmd_src_b)) begin
                                state_d = S_RESP;
                                cnt_d   = {CNT_W{1'b0}};
                                err_d   = 1'b1;
                            end else begin
                                state_d = S_PRE;
                                cnt_d   = CNT_W'(PRE_CYC - 1);
                            end
`else
                            state_d = S_PRE;
                            cnt_d   = CNT_W'(PRE_CYC - 1);
`endif
                        end
                        default: state_d = S_IDLE;
                    endcase
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PRE: begin
                if (cnt_q == {CNT_W{1'b0}}) begin
                    state_d = S_EVAL;
                    cnt_d   = CNT_W'(EVAL_CYC - 1);
                end else begin
                    cnt_d   = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            S_EVAL: begin
                if (cnt_q == {CNT_W{1'b0}}) begin
                    sense_d = sa_data;
                    if (op_q == OP_COMPUTE) begin
                        state_d = S_WR;
                        cnt_d   = CNT_W'(WR_CYC - 1);
                    end else begin
                        state_d = S_RESP;
                    end
                end else begin
                    cnt_d   = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            S_WR: begin
                if (cnt_q == {CNT_W{1'b0}}) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d   = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RESP;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output values for the coming cycle, derived from the next state so every port is a flop.
    always_comb begin
        cmd_ready_d = (state_d == S_IDLE);
        pre_d       = (state_d == S_PRE);
        re1_d       = (state_d == S_EVAL);
        re2_d       = (state_d == S_EVAL) && (op_d == OP_COMPUTE);
        ra1_d       = re1_d ? src_a_d : {ADDR_W{1'b0}};
        ra2_d       = re2_d ? src_b_d : {ADDR_W{1'b0}};
        sen_d       = (state_d == S_EVAL) && (cnt_d == {CNT_W{1'b0}});
        we_d        = (state_d == S_WR);
        wa_d        = we_d ? dst_d : {ADDR_W{1'b0}};
        wr_data_d   = {DATA_W{1'b0}};
        if (we_d) begin
            wr_data_d = (op_d == OP_WRITE) ? wdata_d : sense_d;
        end else begin
            wr_data_d = {DATA_W{1'b0}};
        end
        rsp_valid_d = (state_d == S_RESP);
        rsp_data_d  = rsp_valid_d ? sense_d : {DATA_W{1'b0}};
`ifdef IMC_ROW_CONFLICT_EN
        rsp_err_d   = rsp_valid_d && err_d;
`else
        rsp_err_d   = 1'b0;
`endif
    end

    // State, counter and latched command registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            op_q    <= 2'b00;
            src_a_q <= {ADDR_W{1'b0}};
            src_b_q <= {ADDR_W{1'b0}};
            dst_q   <= {ADDR_W{1'b0}};
            wdata_q <= {DATA_W{1'b0}};
            sense_q <= {DATA_W{1'b0}};
`ifdef IMC_ROW_CONFLICT_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            src_a_q <= src_a_d;
            src_b_q <= src_b_d;
            dst_q   <= dst_d;
            wdata_q <= wdata_d;
            sense_q <= sense_d;
`ifdef IMC_ROW_CONFLICT_EN
            err_q   <= err_d;
`endif
        end
    end

    // Registered decoder, strobe and response outputs; reset drops every strobe at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_ready     <= 1'b1;
            precharge_en  <= 1'b0;
            read_enable1  <= 1'b0;
            read_enable2  <= 1'b0;
            read_address1 <= {ADDR_W{1'b0}};
            read_address2 <= {ADDR_W{1'b0}};
            sense_en      <= 1'b0;
            write_enable  <= 1'b0;
            write_address <= {ADDR_W{1'b0}};
            wr_data       <= {DATA_W{1'b0}};
            rsp_valid     <= 1'b0;
            rsp_data      <= {DATA_W{1'b0}};
            rsp_err       <= 1'b0;
        end else begin
            cmd_ready     <= cmd_ready_d;
            precharge_en  <= pre_d;
            read_enable1  <= re1_d;
            read_enable2  <= re2_d;
            read_address1 <= ra1_d;
            read_address2 <= ra2_d;
            sense_en      <= sen_d;
            write_enable  <= we_d;
            write_address <= wa_d;
            wr_data       <= wr_data_d;
            rsp_valid     <= rsp_valid_d;
            rsp_data      <= rsp_data_d;
            rsp_err       <= rsp_err_d;
        end
    end

endmodule

// File: tb/tb_imc_cmd_sequencer.sv
// Randomized self-checking bench for imc_cmd_sequencer; expected per-cycle behaviour comes
// from a phase-timeline model (precharge / evaluate / write / response windows).
module tb_imc_cmd_sequencer;

    localparam int AW = 7;
    localparam int DW = 128;
    localparam int P  = 1;
    localparam int E  = 2;
    localparam int W  = 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_src_a, cmd_src_b, cmd_dst;
    logic [DW-1:0] cmd_wdata, sa_data;
    logic [AW-1:0] read_address1, read_address2, write_address;
    logic          read_enable1, read_enable2, write_enable;
    logic [DW-1:0] wr_data, rsp_data;
    logic          precharge_en, sense_en, rsp_valid, rsp_ready, rsp_err;

    int n_checks = 0;
    int n_errors = 0;

    imc_cmd_sequencer #(.ADDR_W(AW), .DATA_W(DW), .PRE_CYC(P), .EVAL_CYC(E), .WR_CYC(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b), .cmd_dst(cmd_dst),
        .cmd_wdata(cmd_wdata), .sa_data(sa_data),
        .read_address1(read_address1), .read_address2(read_address2),
        .read_enable1(read_enable1), .read_enable2(read_enable2),
        .write_address(write_address), .write_enable(write_enable), .wr_data(wr_data),
        .precharge_en(precharge_en), .sense_en(sense_en),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ctrl_vec();
        return {cmd_ready, precharge_en, read_enable1, read_enable2,
                write_enable, sense_en, rsp_valid, rsp_err};
    endfunction

    task automatic check_all(input string tag, input logic [7:0] ctrl,
                             input logic [AW-1:0] ra1, input logic [AW-1:0] ra2,
                             input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                             input logic [DW-1:0] rd);
        check_eq({tag, ".ctrl"}, 128'(ctrl_vec()), 128'(ctrl));
        check_eq({tag, ".ra1"},  128'(read_address1), 128'(ra1));
        check_eq({tag, ".ra2"},  128'(read_address2), 128'(ra2));
        check_eq({tag, ".wa"},   128'(write_address), 128'(wa));
        check_eq({tag, ".wd"},   wr_data, wd);
        check_eq({tag, ".rd"},   rsp_data, rd);
    endtask

    function automatic logic [DW-1:0] rand_row();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Issues one command from an idle cycle (#1 after a rising edge) and checks every cycle
    // until the sequencer is idle again. delay = response cycles with rsp_ready low.
    task automatic run_cmd(input string tag, input logic [1:0] op, input logic [AW-1:0] a,
                           input logic [AW-1:0] b, input logic [AW-1:0] d,
                           input logic [DW-1:0] wd, input int delay);
        logic [DW-1:0] cap;
        logic [DW-1:0] exp_rd;
        bit            conflict;
        bit            last;
        int            n_pre, n_eval, n_wr;
        cmd_valid = 1'b1; cmd_op = op; cmd_src_a = a; cmd_src_b = b; cmd_dst = d; cmd_wdata = wd;
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_op = 2'($urandom_range(0, 3)); cmd_wdata = rand_row();
        if (op == 2'b00) begin
            check_all({tag, ".nop"}, 8'h80, '0, '0, '0, '0, '0);
            return;
        end
        conflict = 1'b0;
`ifdef IMC_ROW_CONFLICT_EN
        conflict = (op == 2'b11) && (a == b || d == a || d == b);
`endif
        n_pre  = ((op == 2'b01 || op == 2'b11) && !conflict) ? P : 0;
        n_eval = n_pre > 0 ? E : 0;
        n_wr   = ((op == 2'b10 || op == 2'b11) && !conflict) ? W : 0;
        cap    = '0;
        for (int c = 0; c < n_pre + n_eval + n_wr; c++) begin
            sa_data = rand_row();
            if (c < n_pre) begin
                check_all({tag, ".pre"}, 8'b0100_0000, '0, '0, '0, '0, '0);
            end else if (c < n_pre + n_eval) begin
                last = (c == n_pre + n_eval - 1);
                if (last) cap = sa_data;
                check_all({tag, ".eval"}, {3'b001, op == 2'b11, 1'b0, last, 2'b00},
                          a, (op == 2'b11) ? b : '0, '0, '0, '0);
            end else begin
                check_all({tag, ".wr"}, 8'b0000_1000, '0, '0, d,
                          (op == 2'b10) ? wd : cap, '0);
            end
            @(posedge clk); #1;
        end
        exp_rd = (op == 2'b10 || conflict) ? '0 : cap;
        for (int k = 0; k <= delay; k++) begin
            sa_data   = rand_row();
            rsp_ready = (k == delay);
            check_all({tag, ".resp"}, {6'b000000, 1'b1, conflict}, '0, '0, '0, '0, exp_rd);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b0;
        check_all({tag, ".idle"}, 8'h80, '0, '0, '0, '0, '0);
    endtask

    initial begin
        logic [1:0]    op;
        logic [AW-1:0] a, b, d;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_src_a = '0; cmd_src_b = '0;
        cmd_dst = '0; cmd_wdata = '0; sa_data = '0; rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 8'h80, '0, '0, '0, '0, '0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        run_cmd("write5",   2'b10, 7'd0, 7'd0, 7'd5, {16{8'hA5}}, 0);
        run_cmd("read9",    2'b01, 7'd9, 7'd0, 7'd0, '0, 0);
        run_cmd("compute",  2'b11, 7'd3, 7'd7, 7'd12, '0, 0);
        run_cmd("bp_read",  2'b01, 7'd21, 7'd0, 7'd0, '0, 6);
        run_cmd("same_row", 2'b11, 7'd4, 7'd4, 7'd9, '0, 1);
        run_cmd("nop",      2'b00, 7'd1, 7'd2, 7'd3, '0, 0);

        // Abort in the middle of evaluate.
        cmd_valid = 1'b1; cmd_op = 2'b11; cmd_src_a = 7'd10; cmd_src_b = 7'd11; cmd_dst = 7'd12;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        check_eq("mid_eval.re1", 128'(read_enable1), 128'd1);
        rst_n = 1'b0; #1;
        check_all("abort", 8'h80, '0, '0, '0, '0, '0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check_all("post_abort", 8'h80, '0, '0, '0, '0, '0);

        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = 7'($urandom);
            b  = ($urandom_range(0, 3) == 0) ? a : 7'($urandom);
            d  = ($urandom_range(0, 5) == 0) ? b : 7'($urandom);
            run_cmd("rand", op, a, b, d, rand_row(), int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
